// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target standing in for the audio codec.
// Decodes START, {DEV_ADDR,W}, {reg_addr[6:0],reg_data[8:0]} and STOP. It ACKs
// each byte and stores reg_data into an internal register file.
//
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_sclk            I2C clock from the initiator
//   io_sdat           I2C data, open-drain (driven only to 0, otherwise 'z)
//   o_wr_valid        one-cycle pulse per committed word
//   o_wr_addr/data    reg_addr / reg_data of the committed word
//   o_regs            flattened register file, entry k at [9k+8:9k]
//   o_wr_count        committed word count, saturating at 255
//   o_busy            high between START and STOP
//   o_err             sticky: out-of-range reg_addr or STOP mid-word
//
// Optional feature: define I2C_DEGLITCH_EN to add a 3-sample stability filter
// on SCL/SDA after the synchronizers (1-2 cycle glitches are suppressed).
module i2c_codec_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sclk,
    inout  wire                   io_sdat,
    output logic                  o_wr_valid,
    output logic [6:0]            o_wr_addr,
    output logic [8:0]            o_wr_data,
    output logic [NUM_REGS*9-1:0] o_regs,
    output logic [7:0]            o_wr_count,
    output logic                  o_busy,
    output logic                  o_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_HI,
        S_HI_ACK,
        S_LO,
        S_LO_ACK,
        S_DONE,
        S_IGNORE
    } state_t;

    // Input conditioning
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s, sda_s;

    // Protocol state
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             hi_q, hi_d;
    logic                   sda_oe_q, sda_oe_d;

    // Outputs and register file
    logic                   wr_valid_q, wr_valid_d;
    logic [6:0]             wr_addr_q, wr_addr_d;
    logic [8:0]             wr_data_q, wr_data_d;
    logic [7:0]             wr_count_q, wr_count_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [8:0]             regs_q [NUM_REGS];
    logic [8:0]             regs_d [NUM_REGS];

    logic scl_rise, scl_fall, start_det, stop_det;

`ifdef I2C_DEGLITCH_EN
    logic [2:0] scl_hist_q, scl_hist_d;
    logic [2:0] sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d;
    logic       sda_filt_q, sda_filt_d;
`endif

    // Synchronizers, optional stability filter and edge detection
    always_comb begin
        scl_sync_d = SYNC_STAGES'({scl_sync_q, i_sclk});
        sda_sync_d = SYNC_STAGES'({sda_sync_q, io_sdat});
`ifdef I2C_DEGLITCH_EN
        scl_hist_d = {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
        sda_hist_d = {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
        // A level is accepted only after three consecutive equal samples
        scl_filt_d = (scl_hist_q == 3'b111) ? 1'b1 :
                     (scl_hist_q == 3'b000) ? 1'b0 : scl_filt_q;
        sda_filt_d = (sda_hist_q == 3'b111) ? 1'b1 :
                     (sda_hist_q == 3'b000) ? 1'b0 : sda_filt_q;
        scl_s      = scl_filt_q;
        sda_s      = sda_filt_q;
`else
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
`endif
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        // SCL must be high on both samples so an SDA change is a bus condition
        start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        hi_d       = hi_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_count_d = wr_count_q;
        busy_d     = busy_q;
        err_d      = err_q;
        regs_d     = regs_q;

        case (state_q)
            S_ADDR, S_HI, S_LO: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            S_ADDR:  state_d = (shift_d == {DEV_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
                            S_HI: begin
                                hi_d    = shift_d;
                                state_d = S_HI_ACK;
                            end
                            default: state_d = S_LO_ACK;
                        endcase
                    end
                end
            end
            S_ADDR_ACK, S_HI_ACK, S_LO_ACK: begin
                // First falling edge starts the ACK, the next one ends it
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        case (state_q)
                            S_ADDR_ACK: state_d = S_HI;
                            S_HI_ACK:   state_d = S_LO;
                            default: begin
                                state_d    = S_DONE;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = hi_q[7:1];
                                wr_data_d  = {hi_q[0], shift_q};
                                wr_count_d = (wr_count_q == 8'hFF) ? wr_count_q : wr_count_q + 8'd1;
                                if (32'(hi_q[7:1]) < NUM_REGS) begin
                                    for (int unsigned k = 0; k < NUM_REGS; k++) begin
                                        if (32'(hi_q[7:1]) == k) begin
                                            regs_d[k] = {hi_q[0], shift_q};
                                        end
                                    end
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            // Extra bytes after a committed word are not acknowledged
            S_DONE: begin
                if (scl_rise) begin
                    state_d = S_IGNORE;
                end
            end
            default: ;
        endcase

        // Bus conditions override bit handling
        if (stop_det) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == S_HI || state_q == S_HI_ACK || state_q == S_LO) begin
                err_d = 1'b1;
            end
        end else if (start_det) begin
            state_d   = S_ADDR;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            hi_q       <= 8'd0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
            wr_count_q <= 8'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= 9'd0;
            end
`ifdef I2C_DEGLITCH_EN
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
`endif
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hi_q       <= hi_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            regs_q     <= regs_d;
`ifdef I2C_DEGLITCH_EN
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
`endif
        end
    end

    // Open-drain data line
    assign io_sdat = sda_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        o_regs = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            o_regs[k*9 +: 9] = regs_q[k];
        end
    end

    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_count = wr_count_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: a bit-banged I2C initiator drives transactions,
// a byte-level reference model predicts ACKs and committed words, and a
// monitor process pops expected commits whenever o_wr_valid pulses.
module tb_i2c_codec_target;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned RW       = NUM_REGS * 9;
    localparam int          Q        = 8;   // quarter of an SCL period in clk
    localparam int          H        = 16;  // SCL high time in clk
    localparam logic [7:0]  ADDR_W   = 8'h34;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          m_low;
    wire           io_sdat;
    logic          o_wr_valid;
    logic [6:0]    o_wr_addr;
    logic [8:0]    o_wr_data;
    logic [RW-1:0] o_regs;
    logic [7:0]    o_wr_count;
    logic          o_busy;
    logic          o_err;

    always #5 clk = ~clk;

    pullup (io_sdat);
    assign io_sdat = m_low ? 1'b0 : 1'bz;

    i2c_codec_target #(
        .DEV_ADDR   (7'h1A),
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sclk    (sclk),
        .io_sdat   (io_sdat),
        .o_wr_valid(o_wr_valid),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_regs    (o_regs),
        .o_wr_count(o_wr_count),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    typedef struct {
        logic [6:0]    addr;
        logic [8:0]    data;
        logic [7:0]    cnt;
        logic [RW-1:0] regs;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [RW-1:0] exp_regs = '0;
    logic [7:0]    exp_cnt  = 8'd0;
    logic          exp_err  = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START from idle, or repeated START when SCL is low
    task automatic bus_start();
        if (!sclk) begin
            m_low = 1'b0;
            wait_clk(Q);
            sclk = 1'b1;
        end
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        sclk = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_clk(Q);
        sclk = 1'b1;
        wait_clk(H);
        m_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic bus_bit(input logic b);
        m_low = ~b;
        wait_clk(Q);
        sclk = 1'b1;
        wait_clk(H);
        sclk = 1'b0;
        wait_clk(Q);
    endtask

    // Release SDA for the ACK slot and sample it mid SCL-high
    task automatic bus_ack(output logic s);
        m_low = 1'b0;
        wait_clk(Q);
        sclk = 1'b1;
        wait_clk(Q);
        s = io_sdat;
        wait_clk(Q);
        sclk = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_sda, input string nm);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_ack(s);
        chk(nm, 160'(s), 160'(exp_sda));
    endtask

    // One transaction; the model works on whole bytes
    task automatic xact(input logic [7:0] ab, input int nb, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [7:0] d2, input bit end_stop);
        logic acked;
        int   ra;
        exp_t e;
        acked = (ab == ADDR_W);
        bus_start();
        chk("busy_after_start", 160'(o_busy), 160'(1'b1));
        send_byte(ab, ~acked, "addr_ack");
        if (nb > 0) send_byte(d0, ~acked, "hi_ack");
        if (nb > 1) begin
            if (acked) begin
                ra = int'(d0[7:1]);
                if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
                if (ra < int'(NUM_REGS)) exp_regs[ra*9 +: 9] = {d0[0], d1};
                else exp_err = 1'b1;
                e.addr = d0[7:1];
                e.data = {d0[0], d1};
                e.cnt  = exp_cnt;
                e.regs = exp_regs;
                exp_q.push_back(e);
            end
            send_byte(d1, ~acked, "lo_ack");
        end
        if (nb > 2) send_byte(d2, 1'b1, "extra_nack");
        if (end_stop) begin
            if (acked && nb < 2) exp_err = 1'b1;
            bus_stop();
            chk("busy_after_stop", 160'(o_busy), 160'(1'b0));
            chk("err_after_stop", 160'(o_err), 160'(exp_err));
        end
    endtask

    // Monitor: every commit pulse must match the oldest expected word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_wr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit actual=addr %0h data %0h required=no commit",
                             o_wr_addr, o_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 160'(o_wr_addr), 160'(e.addr));
                    chk("wr_data", 160'(o_wr_data), 160'(e.data));
                    chk("wr_count", 160'(o_wr_count), 160'(e.cnt));
                    chk("regs_at_commit", 160'(o_regs), 160'(e.regs));
                end
            end
        end
    end

    initial begin
        logic [7:0] ab, d0, d1, d2;
        int         nb;
        bit         es;

        rst   = 1'b1;
        sclk  = 1'b1;
        m_low = 1'b0;
        wait_clk(4);
        chk("reset_busy", 160'(o_busy), 160'(1'b0));
        chk("reset_err", 160'(o_err), 160'(1'b0));
        chk("reset_count", 160'(o_wr_count), 160'(0));
        chk("reset_regs", 160'(o_regs), 160'(0));
        chk("reset_sda", 160'(io_sdat), 160'(1'b1));
        rst = 1'b0;
        wait_clk(8);

        // Codec init sequence
        xact(ADDR_W, 2, 8'h08, 8'h15, 8'h00, 1'b1);
        xact(ADDR_W, 2, 8'h0E, 8'h42, 8'h00, 1'b1);
        xact(ADDR_W, 2, 8'h10, 8'h19, 8'h00, 1'b1);
        xact(ADDR_W, 2, 8'h12, 8'h01, 8'h00, 1'b1);
        wait_clk(4);
        chk("init_reg4", 160'(o_regs[4*9 +: 9]), 160'(9'h015));
        chk("init_reg7", 160'(o_regs[7*9 +: 9]), 160'(9'h042));
        chk("init_reg8", 160'(o_regs[8*9 +: 9]), 160'(9'h019));
        chk("init_reg9", 160'(o_regs[9*9 +: 9]), 160'(9'h001));
        chk("init_count", 160'(o_wr_count), 160'(4));

`ifdef I2C_DEGLITCH_EN
        // 2-cycle SDA pulse while SCL is high must not look like START/STOP
        m_low = 1'b1;
        wait_clk(2);
        m_low = 1'b0;
        wait_clk(12);
        chk("glitch_no_start", 160'(o_busy), 160'(1'b0));
`endif

        // Wrong address, read bit, repeated START after high byte
        xact(8'h36, 2, 8'h08, 8'h15, 8'h00, 1'b1);
        xact(8'h35, 1, 8'h08, 8'h00, 8'h00, 1'b1);
        xact(ADDR_W, 1, 8'h0C, 8'h00, 8'h00, 1'b0);
        xact(ADDR_W, 2, 8'h0A, 8'h00, 8'h00, 1'b1);
        chk("no_err_yet", 160'(o_err), 160'(1'b0));

        // Highest in-range entry, then out-of-range (ACKed, not stored)
        xact(ADDR_W, 2, 8'h1E, 8'h00, 8'h00, 1'b1);
        xact(ADDR_W, 2, 8'h1F, 8'hA5, 8'h00, 1'b1);
        xact(ADDR_W, 2, 8'h80, 8'h33, 8'h00, 1'b1);

        // Reset in the middle of the low data byte
        bus_start();
        send_byte(ADDR_W, 1'b0, "rst_addr_ack");
        send_byte(8'h0C, 1'b0, "rst_hi_ack");
        bus_bit(1'b1);
        bus_bit(1'b0);
        bus_bit(1'b1);
        m_low = 1'b0;
        rst   = 1'b1;
        wait_clk(1);
        chk("midrst_sda", 160'(io_sdat), 160'(1'b1));
        chk("midrst_valid", 160'(o_wr_valid), 160'(1'b0));
        chk("midrst_addr", 160'(o_wr_addr), 160'(0));
        chk("midrst_data", 160'(o_wr_data), 160'(0));
        chk("midrst_regs", 160'(o_regs), 160'(0));
        chk("midrst_count", 160'(o_wr_count), 160'(0));
        chk("midrst_busy", 160'(o_busy), 160'(1'b0));
        chk("midrst_err", 160'(o_err), 160'(1'b0));
        wait_clk(1);
        rst      = 1'b0;
        exp_regs = '0;
        exp_cnt  = 8'd0;
        exp_err  = 1'b0;
        bus_stop();
        xact(ADDR_W, 2, 8'h0A, 8'h77, 8'h00, 1'b1);

        // Truncated transaction: STOP after the high byte
        xact(ADDR_W, 1, 8'h0C, 8'h00, 8'h00, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            ab = ($urandom_range(0, 9) < 7) ? ADDR_W : 8'($urandom);
            nb = int'($urandom_range(0, 3));
            d0 = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : {3'b000, 4'($urandom), 1'($urandom)};
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            es = (t == 24) || ($urandom_range(0, 3) != 0);
            xact(ab, nb, d0, d1, d2, es);
        end

        wait_clk(20);
        chk("pending_commits", 160'(exp_q.size()), 160'(0));
        chk("final_regs", 160'(o_regs), 160'(exp_regs));
        chk("final_count", 160'(o_wr_count), 160'(exp_cnt));
        chk("final_err", 160'(o_err), 160'(exp_err));
        chk("final_busy", 160'(o_busy), 160'(1'b0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
